// File: rtl/conv_encoder_param.sv
// Rate 1/N, constraint-length K convolutional encoder with a framed
// valid/ready stream interface and optional zero-tail termination.
module conv_encoder_param #(
    parameter int               K         = 3,
    parameter int               N         = 2,
    parameter logic [N*K-1:0]   GEN       = 6'b111_101,
    parameter int               FRAME_LEN = 8,
    parameter int               TAIL_EN   = 1
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_start,
    input  logic         i_valid,
    input  logic         i_data,
    output logic         o_ready,
    output logic [N-1:0] o_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic         o_last,
    output logic         o_busy
);

    localparam int CNT_W  = $clog2(FRAME_LEN + 1);
    localparam int TAIL_W = $clog2(K);
    localparam int HIST_W = K - 1;

    localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(FRAME_LEN - 1);
    localparam logic [TAIL_W-1:0] LAST_TAIL = TAIL_W'(K - 2);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DATA  = 2'd1,
        S_TAIL  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [HIST_W-1:0]   r_hist;
    logic [CNT_W-1:0]    r_bit_cnt;
    logic [TAIL_W-1:0]   r_tail_cnt;
    logic [N-1:0]        r_data;
    logic                r_valid;
    logic                r_last;

    logic                w_room;
    logic                w_accept;
    logic                w_tail_load;
    logic                w_load;
    logic                w_in_bit;
    logic [K-1:0]        w_window;
    logic                w_data_done;
    logic                w_tail_done;
    logic                w_last_nxt;
    logic                w_consume;
    logic                w_frame_start;

    // One output bit per generator: parity of the window masked by its polynomial.
    function automatic logic [N-1:0] encode(input logic [K-1:0] win);
        logic [N-1:0] sym;
        sym = '0;
        for (int m = 0; m < N; m++) begin
            sym[m] = ^(win & GEN[m*K +: K]);
        end
        return sym;
    endfunction

    assign w_room        = !r_valid | i_ready;
    assign w_accept      = (r_state == S_DATA) & i_valid & w_room;
    assign w_tail_load   = (r_state == S_TAIL) & w_room;
    assign w_load        = w_accept | w_tail_load;
    assign w_consume     = r_valid & i_ready;
    assign w_frame_start = (r_state == S_IDLE) & i_start;
    assign w_data_done   = w_accept & (r_bit_cnt == LAST_BIT);
    assign w_tail_done   = w_tail_load & (r_tail_cnt == LAST_TAIL);
    assign w_window      = {w_in_bit, r_hist};

    // Input bit for the window: live data in DATA, injected zero otherwise.
    always_comb begin
        w_in_bit = 1'b0;
        if (w_accept) begin
            w_in_bit = i_data;
        end else begin
            w_in_bit = 1'b0;
        end
    end

    // The frame's final symbol is the last tail symbol, or the last data symbol when unterminated.
    always_comb begin
        w_last_nxt = 1'b0;
        if (TAIL_EN != 0) begin
            w_last_nxt = w_tail_done;
        end else begin
            w_last_nxt = w_data_done;
        end
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_DATA;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_DATA: begin
                if (w_data_done) begin
                    w_state_nxt = (TAIL_EN != 0) ? S_TAIL : S_DRAIN;
                end else begin
                    w_state_nxt = S_DATA;
                end
            end
            S_TAIL: begin
                if (w_tail_done) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_TAIL;
                end
            end
            S_DRAIN: begin
                if (w_consume & r_last) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DRAIN;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // History shifts and counters advance only when a symbol is loaded, so backpressure freezes them.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hist     <= '0;
            r_bit_cnt  <= '0;
            r_tail_cnt <= '0;
        end else if (w_frame_start) begin
            r_hist     <= '0;
            r_bit_cnt  <= '0;
            r_tail_cnt <= '0;
        end else if (w_load) begin
            r_hist <= w_window[K-1:1];
            if (w_accept) begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
            end else begin
                r_tail_cnt <= r_tail_cnt + TAIL_W'(1);
            end
        end else begin
            r_hist     <= r_hist;
            r_bit_cnt  <= r_bit_cnt;
            r_tail_cnt <= r_tail_cnt;
        end
    end

    // Output symbol register; a load wins over a consume so back-to-back symbols keep o_valid high.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_data  <= '0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else if (w_load) begin
            r_data  <= encode(w_window);
            r_valid <= 1'b1;
            r_last  <= w_last_nxt;
        end else if (w_consume) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            r_data  <= r_data;
            r_valid <= r_valid;
            r_last  <= r_last;
        end
    end

    assign o_data  = r_data;
    assign o_valid = r_valid;
    assign o_last  = r_last;
    assign o_busy  = (r_state != S_IDLE);
    assign o_ready = (r_state == S_DATA) & w_room;

endmodule
